// File: rtl/m68k_bus_pkg.sv
// ---------------------------------------------------------------------------
// m68k_bus_pkg
// Shared definitions for the 68k target responder: register offsets decoded
// from A[2:1], STATUS/CTRL bit positions, the bus FSM state encoding and a
// byte-lane merge helper.
// ---------------------------------------------------------------------------
package m68k_bus_pkg;

  // Register offsets selected by A[2:1]
  localparam logic [1:0] OFF_TX     = 2'd0;
  localparam logic [1:0] OFF_RX     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int STAT_TX_FULL = 0;
  localparam int STAT_RX_FULL = 1;

  // CTRL bit positions
  localparam int CTRL_INT2_EN  = 0;
  localparam int CTRL_PCIRQ_EN = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Replace only the lanes whose (active-low) strobe is asserted.
  function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic        uds_n,
                                             input logic        lds_n);
    return {uds_n ? old_v[15:8] : new_v[15:8],
            lds_n ? old_v[7:0]  : new_v[7:0]};
  endfunction

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for one asynchronous 68k strobe.
// Ports:
//   i_clk  bus clock
//   i_rst  synchronous active-high reset (forces both flops to RST_VAL)
//   i_d    asynchronous input
//   o_q    synchronized output
// ---------------------------------------------------------------------------
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/m68k_target_resp.sv
// ---------------------------------------------------------------------------
// m68k_target_resp
// 68k bus target occupying a 64 KB window (A[23:16] == BASE_ADDR) that
// provides a two-way mailbox between the 68k and a 286-side host.
//   TX (68k writes, host pops)  -> raises pc_irq
//   RX (host pushes, 68k reads) -> raises int2_n
// Ports:
//   i_clk, i_rst            bus clock, synchronous active-high reset
//   i_as_n, i_uds_n, i_lds_n, i_rw   asynchronous 68k strobes
//   i_addr[23:1], i_d_in    68k address / write data
//   o_d_out, o_d_oe         read data and its drive enable
//   o_dtack_n, o_dtack_oe   data acknowledge and its drive enable
//   o_int2_n                68k interrupt (low while RX full and enabled)
//   o_pc_irq                host interrupt (high while TX full and enabled)
//   i_pc_rd, o_pc_rdata     host pop of TX mailbox / TX contents
//   i_pc_wr, i_pc_wdata     host push into RX mailbox
// ---------------------------------------------------------------------------
module m68k_target_resp
  import m68k_bus_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'hE9,
  parameter int unsigned WAIT_CYC  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_as_n,
  input  logic        i_uds_n,
  input  logic        i_lds_n,
  input  logic        i_rw,
  input  logic [23:1] i_addr,
  input  logic [15:0] i_d_in,
  output logic [15:0] o_d_out,
  output logic        o_d_oe,
  output logic        o_dtack_n,
  output logic        o_dtack_oe,
  output logic        o_int2_n,
  output logic        o_pc_irq,
  input  logic        i_pc_rd,
  output logic [15:0] o_pc_rdata,
  input  logic        i_pc_wr,
  input  logic [15:0] i_pc_wdata
);

  localparam logic [2:0] LP_WLAST = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

  logic w_as_s, w_uds_s, w_lds_s, w_rw_s;

  sync2 u_sync_as  (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_as_n),  .o_q(w_as_s));
  sync2 u_sync_uds (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_uds_n), .o_q(w_uds_s));
  sync2 u_sync_lds (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_lds_n), .o_q(w_lds_s));
  sync2 u_sync_rw  (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_rw),    .o_q(w_rw_s));

  // Only the window select and register offset bits are decoded.
  logic w_unused_addr;
  assign w_unused_addr = ^i_addr[15:3];

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_armed;
  logic        r_d_oe, r_dtack_oe, r_dtack_n;

  // Access attributes captured when the cycle is accepted
  logic [7:0]  r_addr_hi;
  logic [1:0]  r_off;
  logic        r_rw, r_uds_n, r_lds_n;
  logic [15:0] r_din;
  logic [15:0] r_dout;

  logic [15:0] r_tx, r_rx;
  logic        r_tx_full, r_rx_full;
  logic [1:0]  r_ctrl;
  logic        r_int2_n, r_pc_irq;

  logic w_start, w_hit, w_dec_go, w_enter_ack;
  logic w_wr_tx, w_wr_ctrl, w_rd_rx;

  // r_armed requires AS to be seen high before a new cycle is accepted, so a
  // cycle released early (address miss) is not decoded twice while AS is low.
  assign w_start     = (r_state == ST_IDLE) && r_armed && !w_as_s &&
                       (!w_uds_s || !w_lds_s);
  assign w_hit       = (r_addr_hi == BASE_ADDR);
  assign w_dec_go    = (r_state == ST_DECODE) && !w_as_s && w_hit;
  assign w_enter_ack = (w_dec_go && (WAIT_CYC == 0)) ||
                       ((r_state == ST_WAIT) && !w_as_s && (r_cnt == LP_WLAST));

  assign w_wr_tx   = w_enter_ack && !r_rw && (r_off == OFF_TX);
  assign w_wr_ctrl = w_enter_ack && !r_rw && (r_off == OFF_CTRL);
  assign w_rd_rx   = w_enter_ack &&  r_rw && (r_off == OFF_RX);

  function automatic logic [15:0] rd_mux(input logic [1:0]  off,
                                         input logic [15:0] rx,
                                         input logic        txf,
                                         input logic        rxf,
                                         input logic [1:0]  ctrl);
    logic [15:0] v;
    v = '0;
    unique case (off)
      OFF_RX:     v = rx;
      OFF_STATUS: begin
        v[STAT_TX_FULL] = txf;
        v[STAT_RX_FULL] = rxf;
      end
      OFF_CTRL: begin
        v[CTRL_INT2_EN]  = ctrl[CTRL_INT2_EN];
        v[CTRL_PCIRQ_EN] = ctrl[CTRL_PCIRQ_EN];
      end
      default:    v = '0;
    endcase
    return v;
  endfunction

  // Bus FSM with registered bus-drive outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_d_oe     <= 1'b0;
      r_dtack_oe <= 1'b0;
      r_dtack_n  <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_d_oe     <= 1'b0;
          r_dtack_oe <= 1'b0;
          r_dtack_n  <= 1'b1;
          if (w_as_s) begin
            r_armed <= 1'b1;
          end else if (w_start) begin
            r_armed <= 1'b0;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!w_dec_go) begin
            // Miss or abort before decode: leave the bus untouched.
            r_state    <= ST_RELEASE;
            r_dtack_oe <= 1'b0;
            r_d_oe     <= 1'b0;
          end else if (w_enter_ack) begin
            r_state    <= ST_ACK;
            r_dtack_oe <= 1'b1;
            r_dtack_n  <= 1'b0;
            r_d_oe     <= r_rw;
          end else begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
            r_d_oe  <= r_rw;
          end
        end
        ST_WAIT: begin
          if (w_as_s) begin
            r_state    <= ST_RELEASE;
            r_dtack_oe <= 1'b1;
            r_dtack_n  <= 1'b1;
            r_d_oe     <= 1'b0;
          end else if (w_enter_ack) begin
            r_state    <= ST_ACK;
            r_dtack_oe <= 1'b1;
            r_dtack_n  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ST_ACK: begin
          if (w_as_s) begin
            r_state   <= ST_RELEASE;
            r_dtack_n <= 1'b1;
            r_d_oe    <= 1'b0;
          end
        end
        ST_RELEASE: begin
          r_state    <= ST_IDLE;
          r_dtack_oe <= 1'b0;
          r_dtack_n  <= 1'b1;
          r_d_oe     <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Access capture and read-data latch
  always_ff @(posedge i_clk) begin
    if (w_start) begin
      r_addr_hi <= i_addr[23:16];
      r_off     <= i_addr[2:1];
      r_rw      <= w_rw_s;
      r_uds_n   <= w_uds_s;
      r_lds_n   <= w_lds_s;
      r_din     <= i_d_in;
    end
    if (w_dec_go) begin
      r_dout <= r_rw ? rd_mux(r_off, r_rx, r_tx_full, r_rx_full, r_ctrl) : '0;
    end
  end

  // Mailbox registers, flags and interrupt outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_tx_full <= 1'b0;
      r_rx_full <= 1'b0;
      r_ctrl    <= '0;
      r_int2_n  <= 1'b1;
      r_pc_irq  <= 1'b0;
    end else begin
      if (w_wr_tx) begin
        r_tx <= lane_merge(r_tx, r_din, r_uds_n, r_lds_n);
      end
      if (w_wr_ctrl && !r_lds_n) begin
        r_ctrl <= r_din[1:0];
      end
      if (i_pc_wr) begin
        r_rx <= i_pc_wdata;
      end
      // 68k write beats a same-cycle host pop
      if (w_wr_tx) begin
        r_tx_full <= 1'b1;
      end else if (i_pc_rd) begin
        r_tx_full <= 1'b0;
      end
      // host push beats a same-cycle 68k read clear
      if (i_pc_wr) begin
        r_rx_full <= 1'b1;
      end else if (w_rd_rx) begin
        r_rx_full <= 1'b0;
      end
      r_int2_n <= ~(r_rx_full & r_ctrl[CTRL_INT2_EN]);
      r_pc_irq <= r_tx_full & r_ctrl[CTRL_PCIRQ_EN];
    end
  end

  assign o_d_out    = r_dout;
  assign o_d_oe     = r_d_oe;
  assign o_dtack_n  = r_dtack_n;
  assign o_dtack_oe = r_dtack_oe;
  assign o_int2_n   = r_int2_n;
  assign o_pc_irq   = r_pc_irq;
  assign o_pc_rdata = r_tx;

endmodule

// File: tb/tb_m68k_target_resp.sv
// ---------------------------------------------------------------------------
// tb_m68k_target_resp
// Directed bench for the 68k mailbox target. Drives 68k bus cycles and
// host push/pop pulses, checking against hand-computed values.
// ---------------------------------------------------------------------------
module tb_m68k_target_resp;
  import m68k_bus_pkg::*;

  localparam int         WAIT_CYC = 2;
  // Edges from the first edge that sees AS low to the edge driving DTACK low
  localparam int         LAT      = 2 + WAIT_CYC + 1;
  localparam logic [7:0] BASE     = 8'hE9;

  logic        clk = 1'b0;
  logic        rst;
  logic        as_n, uds_n, lds_n, rw;
  logic [22:0] addr;
  logic [15:0] d_in;
  logic [15:0] d_out;
  logic        d_oe, dtack_n, dtack_oe, int2_n, pc_irq;
  logic        pc_rd, pc_wr;
  logic [15:0] pc_rdata, pc_wdata;

  always #5 clk = ~clk;

  m68k_target_resp #(.BASE_ADDR(BASE), .WAIT_CYC(WAIT_CYC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_as_n(as_n), .i_uds_n(uds_n), .i_lds_n(lds_n), .i_rw(rw),
    .i_addr(addr), .i_d_in(d_in),
    .o_d_out(d_out), .o_d_oe(d_oe),
    .o_dtack_n(dtack_n), .o_dtack_oe(dtack_oe),
    .o_int2_n(int2_n), .o_pc_irq(pc_irq),
    .i_pc_rd(pc_rd), .o_pc_rdata(pc_rdata),
    .i_pc_wr(pc_wr), .i_pc_wdata(pc_wdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Results of the most recent bus_cycle
  logic        b_acked, b_doe_ack, b_saw_doe, b_saw_dtoe;
  logic [15:0] b_rdata;
  int          b_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] mk_addr(input logic [7:0] hi, input logic [1:0] off);
    return {hi, 13'h0000, off};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pc_push(input logic [15:0] d);
    @(negedge clk);
    pc_wr = 1'b1; pc_wdata = d;
    @(negedge clk);
    pc_wr = 1'b0;
  endtask

  task automatic pc_pop();
    @(negedge clk);
    pc_rd = 1'b1;
    @(negedge clk);
    pc_rd = 1'b0;
  endtask

  // One 68k cycle. pop_at/push_at name the negedge count (after AS falls) at
  // which a one-cycle host pop/push is presented; -1 disables it.
  task automatic bus_cycle(input logic wr_n, input logic [7:0] hi, input logic [1:0] off,
                           input logic [15:0] d, input logic u_n, input logic l_n,
                           input int pop_at, input int push_at, input logic [15:0] push_d);
    int cnt;
    int rel;
    b_acked = 1'b0; b_doe_ack = 1'b0; b_saw_doe = 1'b0; b_saw_dtoe = 1'b0;
    b_rdata = '0; b_lat = -1;
    @(negedge clk);
    addr = mk_addr(hi, off); d_in = d; rw = wr_n; uds_n = u_n; lds_n = l_n; as_n = 1'b0;
    cnt = 0;
    while (!b_acked && cnt < 12) begin
      @(negedge clk);
      cnt++;
      pc_rd = (cnt == pop_at);
      pc_wr = (cnt == push_at);
      pc_wdata = push_d;
      if (d_oe) b_saw_doe = 1'b1;
      if (dtack_oe) b_saw_dtoe = 1'b1;
      if (dtack_oe && !dtack_n) begin
        b_acked = 1'b1; b_lat = cnt - 1; b_rdata = d_out; b_doe_ack = d_oe;
      end
    end
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; pc_rd = 1'b0; pc_wr = 1'b0;
    rel = 0;
    do begin
      @(negedge clk);
      rel++;
      if (d_oe) b_saw_doe = 1'b1;
      if (dtack_oe) b_saw_dtoe = 1'b1;
    end while ((dtack_oe || d_oe) && rel < 10);
    chk("bus_release", {30'b0, dtack_oe, d_oe}, 32'h0);
    idle(2);
  endtask

  task automatic wr(input logic [1:0] off, input logic [15:0] d, input logic u_n, input logic l_n);
    bus_cycle(1'b0, BASE, off, d, u_n, l_n, -1, -1, 16'h0);
  endtask

  task automatic rd(input logic [1:0] off);
    bus_cycle(1'b1, BASE, off, 16'h0, 1'b0, 1'b0, -1, -1, 16'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ab_ack, ab_oe7, got;
    rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    addr = '0; d_in = '0; pc_rd = 1'b0; pc_wr = 1'b0; pc_wdata = '0;
    idle(3);
    chk("rst_dtack_oe", dtack_oe, 0);
    chk("rst_dtack_n",  dtack_n,  1);
    chk("rst_d_oe",     d_oe,     0);
    chk("rst_int2_n",   int2_n,   1);
    chk("rst_pc_irq",   pc_irq,   0);
    chk("rst_pc_rdata", pc_rdata, 0);
    rst = 1'b0;
    idle(2);

    // TX write with pc_irq enabled
    wr(OFF_CTRL, 16'h0002, 1'b0, 1'b0);
    chk("ctrl_wr_ack", b_acked, 1);
    wr(OFF_TX, 16'hA55A, 1'b0, 1'b0);
    chk("tx_wr_ack", b_acked, 1);
    chk("tx_wr_lat", b_lat, LAT);
    chk("tx_wr_no_doe", b_saw_doe, 0);
    chk("pc_irq_set", pc_irq, 1);
    chk("pc_rdata_a55a", pc_rdata, 16'hA55A);
    rd(OFF_STATUS);
    chk("stat_doe", b_doe_ack, 1);
    chk("stat_txfull", b_rdata, 16'h0001);
    rd(OFF_CTRL);
    chk("ctrl_rd", b_rdata, 16'h0002);
    rd(OFF_TX);
    chk("tx_rd_ack", b_acked, 1);
    chk("tx_rd_zero", b_rdata, 16'h0000);
    chk("tx_rd_keep", pc_rdata, 16'hA55A);

    // Host pop, then host push to RX with int2 enabled
    pc_pop();
    idle(2);
    chk("pc_irq_clr", pc_irq, 0);
    wr(OFF_CTRL, 16'h0001, 1'b0, 1'b0);
    pc_push(16'h1234);
    idle(2);
    chk("int2_set", int2_n, 0);
    rd(OFF_RX);
    chk("rx_rd_doe", b_doe_ack, 1);
    chk("rx_rd_data", b_rdata, 16'h1234);
    chk("int2_clr", int2_n, 1);
    rd(OFF_STATUS);
    chk("stat_empty", b_rdata, 16'h0000);

    // Byte-lane writes
    wr(OFF_TX, 16'h0000, 1'b0, 1'b0);
    wr(OFF_TX, 16'hFF77, 1'b1, 1'b0);
    chk("tx_lds_only", pc_rdata, 16'h0077);
    wr(OFF_TX, 16'h12AB, 1'b0, 1'b1);
    chk("tx_uds_only", pc_rdata, 16'h1277);

    // Window miss: no drive at all
    bus_cycle(1'b0, 8'hE8, OFF_TX, 16'hBEEF, 1'b0, 1'b0, -1, -1, 16'h0);
    chk("miss_wr_ack", b_acked, 0);
    chk("miss_wr_dtoe", b_saw_dtoe, 0);
    chk("miss_wr_doe", b_saw_doe, 0);
    chk("miss_wr_tx", pc_rdata, 16'h1277);
    bus_cycle(1'b1, 8'hE8, OFF_STATUS, 16'h0, 1'b0, 1'b0, -1, -1, 16'h0);
    chk("miss_rd_dtoe", b_saw_dtoe, 0);
    chk("miss_rd_doe", b_saw_doe, 0);

    // TX write coincident with host pop (tx_full already 1): write wins
    bus_cycle(1'b0, BASE, OFF_TX, 16'h5A5A, 1'b0, 1'b0, LAT, -1, 16'h0);
    chk("race_tx_ack", b_acked, 1);
    chk("race_tx_data", pc_rdata, 16'h5A5A);
    rd(OFF_STATUS);
    chk("race_tx_full", b_rdata, 16'h0001);
    pc_pop();
    rd(OFF_STATUS);
    chk("pop_clears", b_rdata, 16'h0000);

    // RX read clear coincident with host push: push wins
    pc_push(16'h1111);
    bus_cycle(1'b1, BASE, OFF_RX, 16'h0, 1'b0, 1'b0, -1, LAT, 16'h2222);
    chk("race_rx_data", b_rdata, 16'h1111);
    rd(OFF_STATUS);
    chk("race_rx_full", b_rdata, 16'h0002);
    rd(OFF_RX);
    chk("rx_second", b_rdata, 16'h2222);
    rd(OFF_STATUS);
    chk("rx_drained", b_rdata, 16'h0000);

    // Aborted write: synchronized AS rises while the FSM is in WAIT
    @(negedge clk);
    addr = mk_addr(BASE, OFF_TX); d_in = 16'hDEAD; rw = 1'b0;
    uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    ab_ack = 1'b0; ab_oe7 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 3) begin
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      end
      if (dtack_oe && !dtack_n) ab_ack = 1'b1;
      if (c == 7) ab_oe7 = dtack_oe;
    end
    chk("abort_no_ack", ab_ack, 0);
    chk("abort_idle", ab_oe7, 0);
    chk("abort_tx_kept", pc_rdata, 16'h5A5A);
    rd(OFF_STATUS);
    chk("abort_no_flag", b_rdata, 16'h0000);
    wr(OFF_TX, 16'h0F0F, 1'b0, 1'b0);
    chk("post_abort_ack", b_acked, 1);
    chk("post_abort_tx", pc_rdata, 16'h0F0F);

    // Reset asserted while a STATUS read is being acknowledged
    pc_push(16'h3333);
    wr(OFF_CTRL, 16'h0003, 1'b0, 1'b0);
    idle(2);
    chk("pre_rst_int2", int2_n, 0);
    chk("pre_rst_irq", pc_irq, 1);
    @(negedge clk);
    addr = mk_addr(BASE, OFF_STATUS); rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (dtack_oe && !dtack_n) got = 1'b1;
    end
    chk("rst_pre_ack", got, 1);
    chk("rst_pre_doe", d_oe, 1);
    chk("rst_pre_dout", d_out, 16'h0003);
    rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_dtoe", dtack_oe, 0);
    chk("mid_rst_doe", d_oe, 0);
    chk("mid_rst_dtn", dtack_n, 1);
    chk("mid_rst_irq", pc_irq, 0);
    chk("mid_rst_int2", int2_n, 1);
    chk("mid_rst_tx", pc_rdata, 16'h0000);
    rst = 1'b0;
    idle(2);
    rd(OFF_STATUS);
    chk("post_rst_stat", b_rdata, 16'h0000);
    rd(OFF_CTRL);
    chk("post_rst_ctrl", b_rdata, 16'h0000);
    rd(OFF_RX);
    chk("post_rst_rx", b_rdata, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
